scalar_mul_ctrl: RTL and testbench

//  Constant-time Montgomery-ladder scalar multiplier Q = k*P on the Edwards curve.

---
 rtl/scalar_mul_ctrl_pkg.sv | 38 +++
 rtl/scalar_mul_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_scalar_mul_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_mul_ctrl_pkg.sv
// Shared types and constants for the Montgomery-ladder scalar multiplier.
//  DATA_WIDTH     : coordinate width of every projective (X,Y,Z) value
//  ONE_MONT       : the field element 1 in the Montgomery domain used by mul_mont
//  ladder_state_t : ladder sequencer states
//  point_t        : one projective point, used for the R0/R1 ladder registers
package scalar_mul_ctrl_pkg;

   localparam int unsigned DATA_WIDTH = 256;

   // R = 2^256 and p = 2^255 - 19, so 1*R mod p = 38.
   localparam logic [DATA_WIDTH-1:0] ONE_MONT = DATA_WIDTH'(38);

   typedef enum logic [2:0] {
      StFlush,
      StIdle,
      StAddIssue,
      StAddWait,
      StDblIssue,
      StDblWait,
      StDone
   } ladder_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] x;
      logic [DATA_WIDTH-1:0] y;
      logic [DATA_WIDTH-1:0] z;
   } point_t;

   // Neutral element (0 : 1 : 1) in projective Montgomery form.
   function automatic point_t identity_pt();
      point_t p;
      p.x = '0;
      p.y = ONE_MONT;
      p.z = ONE_MONT;
      return p;
   endfunction

endpackage

// File: rtl/scalar_mul_ctrl.sv
// Constant-time Montgomery-ladder scalar multiplier Q = k*P.
// Sequences one external, shared, unified point_add unit: every scalar bit costs exactly
// one add (R0+R1) and one double (R+R), so the schedule does not depend on k.
// Ports:
//  clk, rst_n              clock, asynchronous active-low reset
//  start, k, Px/Py/Pz      request (honoured only while busy==0), scalar and input point
//  busy, done              busy from accepted start (or reset) until done; done is 1 cycle
//  Qx/Qy/Qz                result, valid with done, held until the next accepted start
//  pa_start                1-cycle start pulse to point_add
//  pa_X1..pa_Z1, pa_X2..   point_add operands, held stable while an op is pending
//  pa_X3..pa_Z3, pa_done   point_add result and completion pulse
module scalar_mul_ctrl
   import scalar_mul_ctrl_pkg::*;
#(
   parameter int unsigned SCALAR_BITS  = 256,
   parameter int unsigned FLUSH_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [SCALAR_BITS-1:0] k,
   input  logic [DATA_WIDTH-1:0]  Px,
   input  logic [DATA_WIDTH-1:0]  Py,
   input  logic [DATA_WIDTH-1:0]  Pz,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  Qx,
   output logic [DATA_WIDTH-1:0]  Qy,
   output logic [DATA_WIDTH-1:0]  Qz,
   output logic                   pa_start,
   output logic [DATA_WIDTH-1:0]  pa_X1,
   output logic [DATA_WIDTH-1:0]  pa_Y1,
   output logic [DATA_WIDTH-1:0]  pa_Z1,
   output logic [DATA_WIDTH-1:0]  pa_X2,
   output logic [DATA_WIDTH-1:0]  pa_Y2,
   output logic [DATA_WIDTH-1:0]  pa_Z2,
   input  logic [DATA_WIDTH-1:0]  pa_X3,
   input  logic [DATA_WIDTH-1:0]  pa_Y3,
   input  logic [DATA_WIDTH-1:0]  pa_Z3,
   input  logic                   pa_done
);

   localparam int unsigned IdxW   = (SCALAR_BITS > 1) ? $clog2(SCALAR_BITS) : 1;
   localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

   ladder_state_t          state_q, state_d;
   logic [SCALAR_BITS-1:0] k_q, k_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [FlushW-1:0]      flush_cnt_q, flush_cnt_d;
   point_t                 r0_q, r0_d;
   point_t                 r1_q, r1_d;
   point_t                 op1_q, op1_d;
   point_t                 op2_q, op2_d;
   point_t                 res_q, res_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pa_start_q, pa_start_d;

   point_t pa_sum;
   point_t p_in;
   point_t dbl_src;
   logic   cur_bit;

   assign pa_sum  = '{x: pa_X3, y: pa_Y3, z: pa_Z3};
   assign p_in    = '{x: Px, y: Py, z: Pz};
   assign cur_bit = k_q[idx_q];

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      idx_d       = idx_q;
      flush_cnt_d = flush_cnt_q;
      r0_d        = r0_q;
      r1_d        = r1_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      res_d       = res_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pa_start_d  = 1'b0;
      dbl_src     = r0_q;

      unique case (state_q)
         // point_add has no reset; wait out any op orphaned by a mid-run reset so its
         // late pa_done cannot be mistaken for a fresh result.
         StFlush: begin
            if (flush_cnt_q == '0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end

         StIdle: begin
            if (start) begin
               k_d        = k;
               r0_d       = identity_pt();
               r1_d       = p_in;
               idx_d      = IdxW'(SCALAR_BITS - 1);
               busy_d     = 1'b1;
               op1_d      = identity_pt();
               op2_d      = p_in;
               pa_start_d = 1'b1;
               state_d    = StAddIssue;
            end
         end

         StAddIssue: state_d = StAddWait;

         StAddWait: begin
            if (pa_done) begin
               if (cur_bit) begin
                  r0_d = pa_sum;
               end else begin
                  r1_d = pa_sum;
               end
               // Double the register the add did not overwrite.
               dbl_src    = cur_bit ? r1_d : r0_d;
               op1_d      = dbl_src;
               op2_d      = dbl_src;
               pa_start_d = 1'b1;
               state_d    = StDblIssue;
            end
         end

         StDblIssue: state_d = StDblWait;

         StDblWait: begin
            if (pa_done) begin
               if (cur_bit) begin
                  r1_d = pa_sum;
               end else begin
                  r0_d = pa_sum;
               end
               if (idx_q == '0) begin
                  // Q and done land on the same edge, so take R0 after this write-back.
                  res_d   = r0_d;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  idx_d      = idx_q - 1'b1;
                  op1_d      = r0_d;
                  op2_d      = r1_d;
                  pa_start_d = 1'b1;
                  state_d    = StAddIssue;
               end
            end
         end

         // busy drops only when leaving, so a start coinciding with done is ignored.
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end

         default: begin
            state_d = StFlush;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFlush;
         k_q         <= '0;
         idx_q       <= '0;
         flush_cnt_q <= FlushW'(FLUSH_CYCLES);
         r0_q        <= '0;
         r1_q        <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         res_q       <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         pa_start_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         idx_q       <= idx_d;
         flush_cnt_q <= flush_cnt_d;
         r0_q        <= r0_d;
         r1_q        <= r1_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         res_q       <= res_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pa_start_q  <= pa_start_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign pa_start = pa_start_q;
   assign Qx       = res_q.x;
   assign Qy       = res_q.y;
   assign Qz       = res_q.z;
   assign pa_X1    = op1_q.x;
   assign pa_Y1    = op1_q.y;
   assign pa_Z1    = op1_q.z;
   assign pa_X2    = op2_q.x;
   assign pa_Y2    = op2_q.y;
   assign pa_Z2    = op2_q.z;

endmodule

// File: tb/tb_scalar_mul_ctrl.sv
// Bench for scalar_mul_ctrl. The point_add stand-in implements an abelian group of prime
// order l on (X,Y,Z): X adds mod l, Y and Z add mod l offset by ONE_MONT, so the identity
// is (0,ONE,ONE). The reference result for k*P is then closed-form multiplication mod l.
module tb_scalar_mul_ctrl;
   import scalar_mul_ctrl_pkg::*;

   localparam int unsigned SB  = 256;
   localparam int unsigned FC  = 24;
   localparam int unsigned TPA = 3;
   localparam int unsigned W   = DATA_WIDTH;
   localparam int unsigned LAT = 2 + SB * (2 + 2 * TPA);
   localparam logic [W-1:0] L =
      256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [SB-1:0] k;
   logic [W-1:0]  Px, Py, Pz;
   logic          busy, done;
   logic [W-1:0]  Qx, Qy, Qz;
   logic          pa_start;
   logic [W-1:0]  pa_X1, pa_Y1, pa_Z1, pa_X2, pa_Y2, pa_Z2;
   logic [W-1:0]  pa_X3 = '0, pa_Y3 = '0, pa_Z3 = '0;
   logic          pa_done = 1'b0;

   scalar_mul_ctrl #(
      .SCALAR_BITS (SB),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .k       (k),
      .Px      (Px),
      .Py      (Py),
      .Pz      (Pz),
      .busy    (busy),
      .done    (done),
      .Qx      (Qx),
      .Qy      (Qy),
      .Qz      (Qz),
      .pa_start(pa_start),
      .pa_X1   (pa_X1),
      .pa_Y1   (pa_Y1),
      .pa_Z1   (pa_Z1),
      .pa_X2   (pa_X2),
      .pa_Y2   (pa_Y2),
      .pa_Z2   (pa_Z2),
      .pa_X3   (pa_X3),
      .pa_Y3   (pa_Y3),
      .pa_Z3   (pa_Z3),
      .pa_done (pa_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Group law of the point_add stand-in.
   function automatic logic [W-1:0] gadd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = s % {1'b0, L};
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] goff(input logic [W-1:0] a, input logic [W-1:0] b);
      return ONE_MONT + gadd(a - ONE_MONT, b - ONE_MONT);
   endfunction

   // point_add stand-in: fixed latency TPA, no reset (like the real unit).
   logic [W-1:0] s_x1, s_y1, s_z1, s_x2, s_y2, s_z2;
   int           s_cnt  = 0;
   bit           s_pend = 1'b0;
   always @(posedge clk) begin
      pa_done <= 1'b0;
      if (s_cnt > 0) begin
         s_cnt <= s_cnt - 1;
         if (s_cnt == 1) begin
            pa_done <= 1'b1;
            pa_X3   <= gadd(s_x1, s_x2);
            pa_Y3   <= goff(s_y1, s_y2);
            pa_Z3   <= goff(s_z1, s_z2);
            s_pend  <= 1'b0;
         end
      end
      if (pa_start) begin
         s_x1   <= pa_X1;
         s_y1   <= pa_Y1;
         s_z1   <= pa_Z1;
         s_x2   <= pa_X2;
         s_y2   <= pa_Y2;
         s_z2   <= pa_Z2;
         s_pend <= 1'b1;
         s_cnt  <= TPA - 1;
      end
   end

   typedef struct {
      logic [W-1:0] qx;
      logic [W-1:0] qy;
      logic [W-1:0] qz;
      int unsigned  st;
   } exp_t;

   exp_t        sb[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          pa_cnt      = 0;
   int          done_cnt    = 0;
   bit          chk_ops     = 1'b0;

   // k*P in the stand-in group: each coordinate scales linearly mod l.
   function automatic logic [W-1:0] gmul(input logic [SB-1:0] kk, input logic [W-1:0] a);
      logic [511:0] t;
      t = 512'(kk) * 512'(a);
      t = t % 512'(L);
      return t[W-1:0];
   endfunction

   function automatic exp_t model(input logic [SB-1:0] kk, input logic [W-1:0] px,
                                  input logic [W-1:0] py, input logic [W-1:0] pz);
      exp_t e;
      e.qx = gmul(kk, px);
      e.qy = ONE_MONT + gmul(kk, py - ONE_MONT);
      e.qz = ONE_MONT + gmul(kk, pz - ONE_MONT);
      e.st = 0;
      return e;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pa_start) begin
               pa_cnt++;
               chk("pa_start_while_pending", W'(s_pend), '0);
            end
            if (pa_done && chk_ops) begin
               chk("op_stable_x1", pa_X1, s_x1);
               chk("op_stable_y1", pa_Y1, s_y1);
               chk("op_stable_z1", pa_Z1, s_z1);
               chk("op_stable_x2", pa_X2, s_x2);
               chk("op_stable_y2", pa_Y2, s_y2);
               chk("op_stable_z2", pa_Z2, s_z2);
            end
            if (done) begin
               done_cnt++;
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_done: done=1 with no outstanding request");
               end else begin
                  e = sb.pop_front();
                  chk("Qx", Qx, e.qx);
                  chk("Qy", Qy, e.qy);
                  chk("Qz", Qz, e.qz);
                  chk("pa_start_count", W'(pa_cnt), W'(2 * SB));
                  chk("latency", W'(cyc - e.st + 1), W'(LAT));
               end
            end
         end
      end
   endtask

   task automatic issue(input logic [SB-1:0] kk, input logic [W-1:0] px,
                        input logic [W-1:0] py, input logic [W-1:0] pz, input bit push);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      k     = kk;
      Px    = px;
      Py    = py;
      Pz    = pz;
      if (push) begin
         e    = model(kk, px, py, pz);
         e.st = cyc;
         sb.push_back(e);
         pa_cnt  = 0;
         chk_ops = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_within_budget", W'(busy), '0);
   endtask

   task automatic wait_done(input int budget);
      int prev;
      int n;
      prev = done_cnt;
      n    = 0;
      while (done_cnt == prev && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == prev) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
   endtask

   task automatic run(input logic [SB-1:0] kk, input logic [W-1:0] px,
                      input logic [W-1:0] py, input logic [W-1:0] pz);
      wait_idle(LAT + 50);
      issue(kk, px, py, pz, 1'b1);
      wait_done(LAT + 50);
   endtask

   logic [W-1:0] bx, by, bz, rx, ry, rz;
   logic [SB-1:0] rk;
   int           npa;
   bit           bad;

   initial begin
      bx    = 256'h0216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51;
      by    = ONE_MONT + 256'h0666666666666666666666666666666666666666666666666666666666666658;
      bz    = ONE_MONT + 256'd5;
      rst_n = 1'b0;
      start = 1'b0;
      k     = '0;
      Px    = '0;
      Py    = '0;
      Pz    = '0;
      fork
         monitor();
      join_none

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), W'(1));
      chk("rst_done", W'(done), '0);
      chk("rst_pa_start", W'(pa_start), '0);
      chk("rst_Qx", Qx, '0);
      chk("rst_Qy", Qy, '0);
      chk("rst_Qz", Qz, '0);
      rst_n = 1'b1;
      repeat (FC) @(negedge clk);
      chk("flush_busy", W'(busy), W'(1));
      wait_idle(8);

      // Directed scalars, including group-order boundaries.
      run('0, bx, by, bz);
      run(SB'(1), bx, by, bz);
      run(SB'(2), bx, by, bz);
      run(SB'(32'hDEADBEEF), bx, by, bz);
      run(L, bx, by, bz);
      run(L - 1, bx, by, bz);

      // Random scalars and points.
      for (int i = 0; i < 4; i++) begin
         rx = rand_w() % L;
         ry = ONE_MONT + (rand_w() % L);
         rz = ONE_MONT + (rand_w() % L);
         run(rand_w(), rx, ry, rz);
      end

      // Start while busy is ignored.
      wait_idle(LAT + 50);
      rk = rand_w();
      issue(rk, bx, by, bz, 1'b1);
      repeat (300) @(negedge clk);
      chk("busy_mid_run", W'(busy), W'(1));
      issue(~rk, by, bx, bz, 1'b0);
      wait_done(LAT + 50);

      // Start in the same cycle as done is ignored.
      wait_idle(LAT + 50);
      issue(SB'(9), bx, by, bz, 1'b1);
      npa = 0;
      while (!done && npa < LAT + 50) begin
         @(negedge clk);
         npa++;
      end
      chk("done_seen", W'(done), W'(1));
      start = 1'b1;
      k     = SB'(5);
      @(negedge clk);
      start  = 1'b0;
      pa_cnt = 0;
      chk("start_on_done_busy", W'(busy), '0);
      repeat (10) @(negedge clk);
      chk("start_on_done_no_ops", W'(pa_cnt), '0);
      chk("start_on_done_idle", W'(busy), '0);

      // Reset during a doubling wait, then a clean run.
      wait_idle(LAT + 50);
      issue(rand_w(), bx, by, bz, 1'b1);
      npa = 0;
      for (int i = 0; i < 100 && npa < 4; i++) begin
         @(negedge clk);
         if (pa_start) npa++;
      end
      chk("fourth_pa_start", W'(npa), W'(4));
      @(negedge clk);
      rst_n   = 1'b0;
      chk_ops = 1'b0;
      sb.delete();
      #1;
      chk("abort_busy", W'(busy), W'(1));
      chk("abort_done", W'(done), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad   = 1'b0;
      repeat (FC) begin
         @(negedge clk);
         if (done || !busy || pa_start) bad = 1'b1;
      end
      chk("flush_after_abort", W'(bad), '0);
      wait_idle(8);
      run(SB'(3), bx, by, bz);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", W'(sb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
